// File: rtl/conv_pkg.sv
// Shared constants, state encoding and IEEE-754 single field helpers for the
// fixed-point <-> float conversion paths.
package conv_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fp_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [FP_MAN_W-1:0] fp_man(input logic [31:0] f);
    return f[22:0];
  endfunction

  function automatic logic [31:0] fp_pack(input logic s,
                                          input logic [FP_EXP_W-1:0] e,
                                          input logic [FP_MAN_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/lead_zero_cnt.sv
// Combinational leading-zero counter (priority encoder from the MSB).
// Only compiled for the single-step normaliser build (CONVERT_FAST_NORM_EN).
`ifdef CONVERT_FAST_NORM_EN
module lead_zero_cnt #(
  parameter int W = 16
) (
  input  logic [W-1:0]           value,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CW = $clog2(W + 1);

  // Highest set bit wins because it is visited last.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

endmodule
`endif

// File: rtl/convert_z_r_seq.sv
// Signed fixed-point sample to IEEE-754 single converter, exact (IN_W <= 24).
// CONVERT_FAST_NORM_EN selects single-step normalisation via lead_zero_cnt.
//
//   state | meaning
//   IDLE  | ready for a sample; capture sign, magnitude, clear cnt
//   NORM  | normalise magnitude until its MSB is set, then pack out_R
//   DONE  | out_R valid and held until out_ready
module convert_z_r_seq
  import conv_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_Z,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [31:0]     out_R,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int         CNT_W    = $clog2(IN_W + 1);
  localparam logic [8:0] EXP_BASE = 9'(FP_EXP_BIAS + IN_W - 1 - FRAC_BITS);

  state_t            state_q, state_d;
  logic [IN_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [31:0]       out_r_q, out_r_d;

  // frac is the normalised magnitude without its implicit leading one.
  function automatic logic [31:0] pack(input logic s,
                                       input logic [IN_W-2:0] frac,
                                       input logic [CNT_W-1:0] c);
    logic [FP_EXP_W-1:0] e;
    logic [FP_MAN_W-1:0] m;
    e = FP_EXP_W'(EXP_BASE - 9'(c));
    m = FP_MAN_W'(frac) << (FP_MAN_W - IN_W + 1);
    return fp_pack(s, e, m);
  endfunction

`ifdef CONVERT_FAST_NORM_EN
  logic [CNT_W-1:0] lz;
  logic [IN_W-1:0]  norm_mag;

  lead_zero_cnt #(.W(IN_W)) u_lzc (
    .value (mag_q),
    .count (lz)
  );

  assign norm_mag = mag_q << lz;
`endif

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    out_r_d = out_r_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_Z[IN_W-1];
          mag_d   = in_Z[IN_W-1] ? (~in_Z + IN_W'(1)) : in_Z;
          cnt_d   = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        // A zero sample spends one cycle here so it keeps the one-edge
        // latency of the shortest nonzero case; it always packs as +0.0.
        if (mag_q == '0) begin
          out_r_d = 32'h0;
          state_d = DONE;
        end else begin
`ifdef CONVERT_FAST_NORM_EN
          mag_d   = norm_mag;
          cnt_d   = lz;
          out_r_d = pack(sign_q, norm_mag[IN_W-2:0], lz);
          state_d = DONE;
`else
          if (mag_q[IN_W-1]) begin
            out_r_d = pack(sign_q, mag_q[IN_W-2:0], cnt_q);
            state_d = DONE;
          end else begin
            mag_d = mag_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      out_r_q <= 32'h0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      out_r_q <= out_r_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_R     = out_r_q;

endmodule

// File: tb/tb_convert_z_r_seq.sv
// Directed bench for convert_z_r_seq: an integer instance (FRAC_BITS=0) and a
// Q8 instance (FRAC_BITS=8) run in lockstep on the same input stream.
module tb_convert_z_r_seq;

`ifdef CONVERT_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [15:0] z;
    logic [31:0] r0;
    logic [31:0] r1;
    int          s;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_z = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_r0, out_r1;

  int checks = 0;
  int errors = 0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  convert_z_r_seq #(.IN_W(16), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_Z(in_z), .in_valid(in_valid),
    .in_ready(in_ready0), .out_R(out_r0), .out_valid(out_valid0),
    .out_ready(out_ready)
  );

  convert_z_r_seq #(.IN_W(16), .FRAC_BITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_Z(in_z), .in_valid(in_valid),
    .in_ready(in_ready1), .out_R(out_r1), .out_valid(out_valid1),
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] z);
    int n = 0;
    in_z     = z;
    in_valid = 1'b1;
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("accept_timeout", 32'(in_ready0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid0 && lat < 60);
  endtask

  task automatic run_one(input string tag, input vec_t v);
    int lat;
    send(v.z);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), FAST ? 32'd1 : 32'(1 + v.s));
    check({tag, "_r0"}, out_r0, v.r0);
    check({tag, "_r1"}, out_r1, v.r1);
    check({tag, "_valid1"}, 32'(out_valid1), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_drop"}, {30'd0, out_valid0, in_ready0}, 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{16'h0001, 32'h3F800000, 32'h3B800000, 15};
    vecs[1] = '{16'hFFFF, 32'hBF800000, 32'hBB800000, 15};
    vecs[2] = '{16'h0000, 32'h00000000, 32'h00000000, 0};
    vecs[3] = '{16'd100,  32'h42C80000, 32'h3EC80000, 9};
    vecs[4] = '{16'h8000, 32'hC7000000, 32'hC3000000, 0};
    vecs[5] = '{16'h7FFF, 32'h46FFFE00, 32'h42FFFE00, 1};
    vecs[6] = '{16'h0180, 32'h43C00000, 32'h3FC00000, 7};
    vecs[7] = '{16'hFF80, 32'hC3000000, 32'hBF000000, 8};
    vecs[8] = '{16'hFFFB, 32'hC0A00000, 32'hBCA00000, 13};

    repeat (2) @(negedge clk);
    check("rst_out_r", out_r0, 32'h0);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_one($sformatf("v%0d", i), vecs[i]);

    // Back-pressure: result held while a new sample waits on in_Z.
    out_ready = 1'b0;
    send(16'd100);
    wait_valid(lat);
    check("bp_r0", out_r0, 32'h42C80000);
    in_z     = 16'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_r%0d", i), out_r0, 32'h42C80000);
      check($sformatf("bp_hold_v%0d", i), 32'(out_valid0), 32'd1);
      check($sformatf("bp_hold_rdy%0d", i), 32'(in_ready0), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_after_valid", 32'(out_valid0), 32'd0);
    check("bp_after_ready", 32'(in_ready0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_accepted", 32'(in_ready0), 32'd0);
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_new_lat", 32'(lat), FAST ? 32'd1 : 32'd14);
    check("bp_new_r0", out_r0, 32'h40E00000);
    check("bp_new_r1", out_r1, 32'h3CE00000);
    @(posedge clk);
    @(negedge clk);

    // Reset while normalising in_Z=1.
    send(16'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid0), 32'd0);
    check("midrst_ready", 32'(in_ready0), 32'd1);
    check("midrst_out_r", out_r0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_one("post_rst", '{16'd2, 32'h40000000, 32'h3C000000, 14});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
